scan_chain_ctrl: RTL and testbench
==================================

# scan_chain_ctrl

Sequencer that drives the scan-control pins (NbarT, Si, CE) of a mapped chain of `dff` cells and collects the chain's serial output. It accepts one parallel test pattern per handshake, shifts it into the chain, issues one functional capture cycle, and unloads the captured response while the next pattern shifts in. The block sits directly upstream of the scan flops in fault-simulation and testbench netlists.

## Interface
- `CHAIN_LEN`, 32: number of `dff` cells in the chain, ≥ 2.
- `C`  in  1  clock, rising edge; shared with the chain.
- `global_reset`  in  1  synchronous, active-high reset.
- `pat_valid`  in  1  pattern offered.
- `pat_ready`  out  1  pattern accepted when `pat_valid && pat_ready`.
- `pat_data`  in  CHAIN_LEN  bit i is destined for chain flop i. Flop CHAIN_LEN-1 drives `So`.
- `pat_last`  in  1  marks the final pattern; triggers a flush after its capture.
- `scan_en`  out  1  drives chain NbarT; 1 = shift, 0 = functional.
- `scan_si`  out  1  drives Si of chain flop 0.
- `chain_ce`  out  1  drives chain CE; 0 holds the chain.
- `scan_so`  in  1  Q of chain flop CHAIN_LEN-1.
- `rsp_valid`  out  1  unloaded response available.
- `rsp_ready`  in  1  response consumed on `rsp_valid && rsp_ready`.
- `rsp_data`  out  CHAIN_LEN  bit i = captured value of flop i.
- `done`  out  1  one-cycle pulse at the end of a flush.

## Operation
- All outputs are registered.
- Reset values: `scan_en`, `scan_si`, `chain_ce`, `rsp_valid`, `done` = 0. `rsp_data` = 0. State = IDLE. `have_prev` = 0.
- State machine:
  - **IDLE**: `pat_ready = !rsp_valid`; `chain_ce = 0`. On accept: load the pattern shift register, latch `pat_last`, set cnt = 0, and go to SHIFT.
  - **SHIFT**: `scan_en = 1`, `chain_ce = 1`, `scan_si = pat_sr[CHAIN_LEN-1]`. Each edge does three things:
    - pat_sr shifts left, filling with 0.
    - `rsp_sr <= {rsp_sr[CHAIN_LEN-2:0], scan_so}`.
    - cnt++.
  - SHIFT exit: after CHAIN_LEN edges, go to CAPTURE. If `have_prev`, `rsp_data <= rsp_sr` (final form) and `rsp_valid <= 1`. Then set `have_prev = 1`.
  - **CAPTURE**: exactly one cycle with `scan_en = 0` and `chain_ce = 1`.
    - `!last` → IDLE.
    - `last` → WAIT_FLUSH.
  - **WAIT_FLUSH**: `chain_ce = 0`. Wait until `rsp_valid == 0`, then go to FLUSH with cnt = 0.
  - **FLUSH**: same as SHIFT, but `scan_si = 0`. After CHAIN_LEN edges, present the response, pulse `done`, clear `have_prev`, and go to IDLE.
- Response ordering: response k (captured after pattern k) is unloaded during the shift of pattern k+1, or during FLUSH.
- The response of pattern 0 in a sequence is never dropped. Data unloaded during the first shift after reset or after a flush is discarded (`have_prev = 0`).
- `rsp_valid` holds, with `rsp_data` stable, until `rsp_ready`. `rsp_valid` clears on the handshake edge.
- Backpressure: while `rsp_valid = 1`, no new pattern is accepted and no flush starts. The chain is never shifted into an occupied response slot.
- `pat_valid` while not in IDLE: ignored, `pat_ready = 0`.
- Reset mid-shift or mid-flush: immediate return to IDLE with reset values. The chain contents are undefined; the bench re-initialises them.
- Counter width: `$clog2(CHAIN_LEN+1)`. Terminal count is CHAIN_LEN-1 on the last shift edge, with no wrap.

## Timing
- Pattern accepted at edge t:
  - `scan_en = 1` during cycles t+1 … t+CHAIN_LEN.
  - CAPTURE during cycle t+CHAIN_LEN+1.
- `rsp_valid` rises at edge t+CHAIN_LEN and is visible in the CAPTURE cycle when `have_prev = 1`.
- Minimum pattern period: CHAIN_LEN+2 cycles (shift, capture, IDLE accept), assuming `rsp_ready` is held at 1.
- Flush: `done` and the final `rsp_valid` rise together, CHAIN_LEN cycles after FLUSH entry.
- `pat_ready` and `rsp_ready` may both be high in the same IDLE cycle. The response handshake frees the slot at that edge, so the pattern is accepted one cycle later at the earliest.

## Structure
- Package `scan_ctrl_pkg` holds:
  - the state enum: IDLE, SHIFT, CAPTURE, WAIT_FLUSH, FLUSH;
  - the counter-width function.
- Sub-module `scan_shift_reg`: a CHAIN_LEN-bit register with parallel load, serial in, MSB serial out, and shift enable.
  - Instantiated twice: pattern PISO and response SIPO.
- The top level contains only the FSM, the counter, and the handshake logic.

## Test plan
Bench configuration: CHAIN_LEN = 4. Chain model is four `dff` cells with functional `D = ~Q`, so the expected response equals ~pattern.
- **Single pattern**: `pat_data = 4'b1010`, `last = 1`.
  - `scan_si` sequence is 1,0,1,0.
  - After flush: `rsp_data = 4'b0101` with `done`.
  - Total cycles from accept to `done` = 11 (including WAIT_FLUSH).
- **Streaming**: 3 patterns 0x3, 0xC, 0x9 (`last` on the third), with `rsp_ready = 1`.
  - Responses 0xC, 0x3, 0x6 in order.
  - No response emitted during the first shift.
- **Backpressure**: hold `rsp_ready = 0` after the first response.
  - `pat_ready` stays 0 and `chain_ce` stays 0.
  - Releasing `rsp_ready` resumes the sequence with no lost or duplicated response.
- **Reset mid-shift**: assert `global_reset` at shift cycle 2.
  - Next cycle: all outputs 0, state IDLE.
  - A new single-pattern run then passes.
- **Pattern offered while busy**: `pat_valid` held high throughout.
  - Exactly one accept per IDLE visit.
  - `scan_en` pulse count = 4 per pattern.

Source files
------------

// File: rtl/scan_chain_ctrl_pkg.sv
// scan_ctrl_pkg: sequencer state encoding and counter sizing shared by the scan controller
package scan_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, WAIT_FLUSH, FLUSH} state_e;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/scan_chain_ctrl_if.sv
// scan_chain_ctrl_if: pattern/response handshakes plus the scan pins of the chain
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 32
);
    logic                 pat_valid;
    logic                 pat_ready;
    logic [CHAIN_LEN-1:0] pat_data;
    logic                 pat_last;
    logic                 scan_en;
    logic                 scan_si;
    logic                 chain_ce;
    logic                 scan_so;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;
    logic                 done;
    modport master (
        input  pat_valid, pat_data, pat_last, scan_so, rsp_ready,
        output pat_ready, scan_en, scan_si, chain_ce, rsp_valid, rsp_data, done
    );
    modport slave (
        output pat_valid, pat_data, pat_last, scan_so, rsp_ready,
        input  pat_ready, scan_en, scan_si, chain_ce, rsp_valid, rsp_data, done
    );
endinterface

// File: rtl/scan_chain_ctrl_shift_reg.sv
// scan_shift_reg: parallel-load shift register shifting towards the MSB, serial in at bit 0
module scan_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         si,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    always_comb begin
        q_d = load ? din : shift ? {q_q[W-2:0], si} : q_q;
    end
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: shifts patterns into a scan chain, captures once, unloads the previous response
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32
) (
    input logic               C,
    input logic               global_reset,
    scan_chain_ctrl_if.master bus
);
    localparam int CW = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_q, last_d, have_prev_q, have_prev_d;
    logic                 scan_en_q, scan_en_d, chain_ce_q, chain_ce_d;
    logic                 pat_ready_q, pat_ready_d, rsp_valid_q, rsp_valid_d;
    logic                 done_q, done_d, rsp_set;
    logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_d, pat_q, rsp_q;
    logic                 accept, shifting, term, unused_bits;
    assign accept   = pat_ready_q && bus.pat_valid;
    assign shifting = state_q == SHIFT || state_q == FLUSH;
    assign term     = shifting && cnt_q == LAST;
    // scan_si comes straight from the PISO MSB, which is zero outside SHIFT
    scan_shift_reg #(.W(CHAIN_LEN)) u_pat (
        .clk(C), .rst(global_reset), .load(accept), .din(bus.pat_data),
        .shift(shifting), .si(1'b0), .q(pat_q)
    );
    scan_shift_reg #(.W(CHAIN_LEN)) u_rsp (
        .clk(C), .rst(global_reset), .load(1'b0), .din('0),
        .shift(shifting), .si(bus.scan_so), .q(rsp_q)
    );
    assign unused_bits = ^{pat_q[CHAIN_LEN-2:0], rsp_q[CHAIN_LEN-1]};
    always_comb begin
        state_d     = state_q;
        cnt_d       = shifting ? cnt_q + CW'(1) : cnt_q;
        last_d      = last_q;
        have_prev_d = have_prev_q;
        rsp_set     = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = SHIFT;
                cnt_d   = '0;
                last_d  = bus.pat_last;
            end
            SHIFT: if (term) begin
                state_d     = CAPTURE;
                rsp_set     = have_prev_q;
                have_prev_d = 1'b1;
            end
            CAPTURE: state_d = last_q ? WAIT_FLUSH : IDLE;
            WAIT_FLUSH: if (!rsp_valid_q) begin
                state_d = FLUSH;
                cnt_d   = '0;
            end
            FLUSH: if (term) begin
                state_d     = IDLE;
                rsp_set     = 1'b1;
                done_d      = 1'b1;
                have_prev_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // the final unload bit arrives on the same edge the response is presented
        rsp_valid_d = rsp_set || (rsp_valid_q && !bus.rsp_ready);
        rsp_data_d  = rsp_set ? {rsp_q[CHAIN_LEN-2:0], bus.scan_so} : rsp_data_q;
        scan_en_d   = state_d == SHIFT || state_d == FLUSH;
        chain_ce_d  = scan_en_d || state_d == CAPTURE;
        pat_ready_d = state_d == IDLE && !rsp_valid_d;
    end
    always_ff @(posedge C) begin
        if (global_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            have_prev_q <= 1'b0;
            scan_en_q   <= 1'b0;
            chain_ce_q  <= 1'b0;
            pat_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            have_prev_q <= have_prev_d;
            scan_en_q   <= scan_en_d;
            chain_ce_q  <= chain_ce_d;
            pat_ready_q <= pat_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
        end
    end
    assign bus.pat_ready = pat_ready_q;
    assign bus.scan_en   = scan_en_q;
    assign bus.scan_si   = pat_q[CHAIN_LEN-1];
    assign bus.chain_ce  = chain_ce_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench driving a 4-cell chain whose functional D is ~Q
module tb_scan_chain_ctrl;
    import scan_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] chain;
    logic [3:0] rsp_log[$];
    logic en_prev = 1'b0;
    logic [63:0] en_seq, ce_seq;
    logic [3:0] si_seq;
    logic any_rdy, any_ce, all_v, all_stable;
    int n_tests = 0, n_fail = 0;
    int n_acc = 0, n_pulse = 0, n_en = 0;
    int cyc, acc0, pul0, en0;
    scan_chain_ctrl_if #(.CHAIN_LEN(4)) bus ();
    scan_chain_ctrl #(.CHAIN_LEN(4)) dut (.C(clk), .global_reset(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rst) chain <= '0;
        else if (bus.chain_ce) chain <= bus.scan_en ? {chain[2:0], bus.scan_si} : ~chain;
    end
    assign bus.scan_so = chain[3];
    always @(posedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) rsp_log.push_back(bus.rsp_data);
        if (bus.pat_valid && bus.pat_ready) n_acc++;
        if (bus.scan_en && !en_prev) n_pulse++;
        if (bus.scan_en) n_en++;
        en_prev = bus.scan_en;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [3:0] d, input logic l);
        int n = 0;
        bus.pat_data  = d;
        bus.pat_last  = l;
        bus.pat_valid = 1'b1;
        while (!bus.pat_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pat_accept", 32'(bus.pat_ready), 1);
        @(negedge clk);
        bus.pat_valid = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(bus.done), 1);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.pat_valid = 1'b0;
        bus.pat_data  = '0;
        bus.pat_last  = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_scan_en", 32'(bus.scan_en), 0);
        chk("rst_scan_si", 32'(bus.scan_si), 0);
        chk("rst_chain_ce", 32'(bus.chain_ce), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_pat_ready", 32'(bus.pat_ready), 0);
        rst = 1'b0;
        // single pattern with flush
        send(4'b1010, 1'b1);
        en_seq = '0;
        ce_seq = '0;
        si_seq = '0;
        for (cyc = 1; cyc < 40 && !bus.done; cyc++) begin
            en_seq[cyc] = bus.scan_en;
            ce_seq[cyc] = bus.chain_ce;
            if (cyc <= 4) si_seq = {si_seq[2:0], bus.scan_si};
            @(negedge clk);
        end
        chk("single_si_seq", 32'(si_seq), 32'hA);
        chk("single_en_seq", en_seq[31:0], 32'h79E);
        chk("single_ce_seq", ce_seq[31:0], 32'h7BE);
        chk("single_latency", cyc, 11);
        chk("single_done", 32'(bus.done), 1);
        chk("single_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("single_rsp_data", 32'(bus.rsp_data), 32'h5);
        @(negedge clk);
        chk("single_done_pulse", 32'(bus.done), 0);
        chk("single_rsp_cleared", 32'(bus.rsp_valid), 0);
        chk("single_log_size", rsp_log.size(), 1);
        chk("single_log0", 32'(rsp_log[0]), 32'h5);
        // streaming three patterns
        rsp_log.delete();
        send(4'h3, 1'b0);
        repeat (4) @(negedge clk);
        chk("stream_first_no_rsp", 32'(bus.rsp_valid), 0);
        chk("stream_first_log", rsp_log.size(), 0);
        send(4'hC, 1'b0);
        repeat (4) @(negedge clk);
        chk("stream_cap_scan_en", 32'(bus.scan_en), 0);
        chk("stream_cap_ce", 32'(bus.chain_ce), 1);
        chk("stream_cap_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("stream_cap_rsp_data", 32'(bus.rsp_data), 32'hC);
        send(4'h9, 1'b1);
        wait_done(cyc);
        @(negedge clk);
        chk("stream_log_size", rsp_log.size(), 3);
        chk("stream_log0", 32'(rsp_log[0]), 32'hC);
        chk("stream_log1", 32'(rsp_log[1]), 32'h3);
        chk("stream_log2", 32'(rsp_log[2]), 32'h6);
        // backpressure on the response side
        rsp_log.delete();
        bus.rsp_ready = 1'b0;
        send(4'h5, 1'b0);
        send(4'hA, 1'b0);
        repeat (4) @(negedge clk);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("bp_rsp_data", 32'(bus.rsp_data), 32'hA);
        bus.pat_data  = 4'h6;
        bus.pat_last  = 1'b1;
        bus.pat_valid = 1'b1;
        any_rdy = 1'b0;
        any_ce = 1'b0;
        all_v = 1'b1;
        all_stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            any_rdy |= bus.pat_ready;
            any_ce |= bus.chain_ce;
            all_v &= bus.rsp_valid;
            all_stable &= (bus.rsp_data == 4'hA);
        end
        chk("bp_pat_ready_low", 32'(any_rdy), 0);
        chk("bp_chain_ce_low", 32'(any_ce), 0);
        chk("bp_rsp_held", 32'(all_v), 1);
        chk("bp_rsp_stable", 32'(all_stable), 1);
        bus.rsp_ready = 1'b1;
        send(4'h6, 1'b1);
        wait_done(cyc);
        @(negedge clk);
        chk("bp_log_size", rsp_log.size(), 3);
        chk("bp_log0", 32'(rsp_log[0]), 32'hA);
        chk("bp_log1", 32'(rsp_log[1]), 32'h5);
        chk("bp_log2", 32'(rsp_log[2]), 32'h9);
        // reset during shift cycle 2
        send(4'h3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_scan_en", 32'(bus.scan_en), 0);
        chk("mid_rst_scan_si", 32'(bus.scan_si), 0);
        chk("mid_rst_chain_ce", 32'(bus.chain_ce), 0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        rsp_log.delete();
        send(4'b1100, 1'b1);
        wait_done(cyc);
        chk("post_rst_latency", cyc, 11);
        chk("post_rst_rsp_data", 32'(bus.rsp_data), 32'h3);
        @(negedge clk);
        chk("post_rst_log_size", rsp_log.size(), 1);
        // pat_valid held high across several IDLE visits
        rsp_log.delete();
        acc0 = n_acc;
        pul0 = n_pulse;
        en0 = n_en;
        chk("busy_start_ready", 32'(bus.pat_ready), 1);
        bus.pat_data  = 4'h9;
        bus.pat_last  = 1'b0;
        bus.pat_valid = 1'b1;
        repeat (18) @(negedge clk);
        bus.pat_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_accepts", n_acc - acc0, 3);
        chk("busy_en_pulses", n_pulse - pul0, 3);
        chk("busy_en_cycles", n_en - en0, 12);
        chk("busy_log_size", rsp_log.size(), 2);
        chk("busy_log0", 32'(rsp_log[0]), 32'h6);
        chk("busy_log1", 32'(rsp_log[1]), 32'h6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
